// File: rtl/median_engine_if.sv
// Sample-in / result-out bundle of the median engine.
// Each of the two channels transfers on a rising edge where its VALID and READY are both 1.
interface median_engine_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DI;
    logic             DI_VALID;
    logic             DI_READY;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] DO;
    logic             DO_VALID;
    logic             DO_READY;
    logic             BUSY;
    logic [1:0]       dbg_state;

    modport slave (
        input  DI, DI_VALID, MODE, DO_READY,
        output DI_READY, DO, DO_VALID, BUSY, dbg_state
    );

    modport master (
        output DI, DI_VALID, MODE, DO_READY,
        input  DI_READY, DO, DO_VALID, BUSY, dbg_state
    );
endinterface

// File: rtl/median_engine.sv
// Windowed median/max/min engine: loads NUMBER samples, then extracts the k-th largest
// with a single shared compare-exchange recirculating the sample shift register.
module median_engine #(
    parameter int WIDTH  = 8,
    parameter int NUMBER = 9
) (
    input logic           CLK,
    input logic           RST,
    median_engine_if.slave bus
);
    localparam int CW    = $clog2(NUMBER);
    localparam int MED_P = (NUMBER + 1) / 2;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    pass_q, pass_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] do_q, do_d;
    logic [WIDTH-1:0] smp_q [NUMBER];
    logic [WIDTH-1:0] smp_d [NUMBER];

    logic             is_min;
    logic             better;
    logic [WIDTH-1:0] head, win, lose, neutral;
    logic [CW-1:0]    last_pass;

    // Each pass pulls the running extreme out of the ring and pushes a neutral
    // value back in; median runs MED_P max-passes, the last one yields the median.
    always_comb begin
        is_min    = (mode_q == 2'b10);
        head      = smp_q[0];
        better    = is_min ? (head < acc_q) : (head > acc_q);
        win       = better ? head : acc_q;
        lose      = better ? acc_q : head;
        neutral   = is_min ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        last_pass = (mode_q == 2'b01 || mode_q == 2'b10) ? {CW{1'b0}} : CW'(MED_P - 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        do_d    = do_q;
        smp_d   = smp_q;
        case (state_q)
            S_LOAD: begin
                if (bus.DI_VALID) begin
                    for (int i = 0; i < NUMBER - 1; i++) smp_d[i] = smp_q[i+1];
                    smp_d[NUMBER-1] = bus.DI;
                    if (cnt_q == '0) mode_d = bus.MODE;
                    if (cnt_q == CW'(NUMBER - 1)) begin
                        cnt_d   = '0;
                        pass_d  = '0;
                        acc_d   = neutral;
                        state_d = S_SORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_SORT: begin
                for (int i = 0; i < NUMBER - 1; i++) smp_d[i] = smp_q[i+1];
                smp_d[NUMBER-1] = lose;
                acc_d           = win;
                if (cnt_q == CW'(NUMBER - 1)) begin
                    cnt_d = '0;
                    acc_d = neutral;
                    if (pass_q == last_pass) begin
                        do_d    = win;
                        state_d = S_OUT;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (bus.DO_READY) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            pass_q  <= '0;
            mode_q  <= 2'b00;
            acc_q   <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            do_q    <= do_d;
        end
    end

    // Sample storage is only observed after a full window has been shifted in.
    always_ff @(posedge CLK) begin
        smp_q <= smp_d;
    end

    assign bus.DI_READY  = (state_q == S_LOAD);
    assign bus.DO_VALID  = (state_q == S_OUT);
    assign bus.DO        = do_q;
    assign bus.BUSY      = (state_q != S_LOAD) || (cnt_q != '0);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_median_engine.sv
// Directed bench for median_engine (WIDTH=8, NUMBER=9): vector table plus reset/backpressure sequences.
module tb_median_engine;
  logic CLK = 1'b0;
  logic RST;
  int   tests = 0;
  int   fails = 0;

  median_engine_if #(.WIDTH(8)) bus ();

  median_engine #(.WIDTH(8), .NUMBER(9)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [0:8][7:0] smp;
    logic [1:0]      mode;
    logic [1:0]      mode2;
    bit              toggle;
    bit              gaps;
    logic [7:0]      exp;
    int              lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_vec(input int idx, input logic [0:8][7:0] s, input logic [1:0] m,
                         input logic [1:0] m2, input bit tg, input bit gp,
                         input logic [7:0] e, input int l);
    vecs[idx].smp    = s;
    vecs[idx].mode   = m;
    vecs[idx].mode2  = m2;
    vecs[idx].toggle = tg;
    vecs[idx].gaps   = gp;
    vecs[idx].exp    = e;
    vecs[idx].lat    = l;
  endtask

  task automatic send_window(input vec_t v);
    for (int i = 0; i < 9; i++) begin
      if (v.gaps) begin
        bus.DI_VALID = 1'b0;
        bus.DI       = 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, 3)) tick();
      end
      bus.DI       = v.smp[i];
      bus.DI_VALID = 1'b1;
      bus.MODE     = (i == 0 || !v.toggle) ? v.mode : v.mode2;
      for (int b = 0; b < 100 && !bus.DI_READY; b++) tick();
      tick();
    end
    bus.DI_VALID = 1'b0;
    if (v.toggle) bus.MODE = v.mode2;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!bus.DO_VALID && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    bus.DO_READY = 1'b1;
    send_window(v);
    wait_valid(100, n);
    check({name, "_lat"}, n, v.lat);
    check({name, "_do"}, bus.DO, v.exp);
    tick();
    check({name, "_pulse"}, bus.DO_VALID, 0);
    check({name, "_hold"}, bus.DO, v.exp);
    check({name, "_rdy"}, {bus.DI_READY, bus.BUSY}, 2'b10);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n;
    bit  seen;
    RST          = 1'b1;
    bus.DI       = '0;
    bus.DI_VALID = 1'b0;
    bus.MODE     = 2'b00;
    bus.DO_READY = 1'b0;

    set_vec(0,  {8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4}, 2'b00, 2'b00, 0, 0, 8'd5, 45);
    set_vec(1,  {8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4}, 2'b01, 2'b01, 0, 0, 8'd9, 9);
    set_vec(2,  {8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4}, 2'b10, 2'b10, 0, 0, 8'd1, 9);
    set_vec(3,  {8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4}, 2'b01, 2'b10, 1, 0, 8'd9, 9);
    set_vec(4,  {8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4}, 2'b10, 2'b00, 1, 0, 8'd1, 9);
    set_vec(5,  {8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd255, 8'd255, 8'd7, 8'd0}, 2'b00, 2'b00, 0, 1, 8'd7, 45);
    set_vec(6,  {8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd255, 8'd255, 8'd7, 8'd0}, 2'b11, 2'b11, 0, 1, 8'd7, 45);
    set_vec(7,  {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 2'b10, 2'b10, 0, 0, 8'd255, 9);
    set_vec(8,  {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b01, 2'b01, 0, 1, 8'd0, 9);
    set_vec(9,  {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90}, 2'b00, 2'b00, 0, 0, 8'd50, 45);
    set_vec(10, {8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 2'b11, 2'b01, 1, 0, 8'd50, 45);
    set_vec(11, {8'd3, 8'd200, 8'd3, 8'd200, 8'd3, 8'd200, 8'd3, 8'd200, 8'd3}, 2'b00, 2'b00, 0, 1, 8'd3, 45);

    tick();
    tick();
    RST = 1'b0;
    check("reset_do", bus.DO, 0);
    check("reset_do_valid", bus.DO_VALID, 0);
    check("reset_di_ready", bus.DI_READY, 1);
    check("reset_busy", bus.BUSY, 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: hold result for 10 cycles, DI offered during OUT must be ignored.
    bus.DO_READY = 1'b0;
    send_window(vecs[0]);
    wait_valid(100, n);
    check("bp_lat", n, 45);
    bus.DI       = 8'd99;
    bus.DI_VALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("bp_hold%0d", c), {bus.DO_VALID, bus.DI_READY, bus.DO}, {1'b1, 1'b0, 8'd5});
    end
    bus.DI_VALID = 1'b0;
    bus.DO_READY = 1'b1;
    tick();
    check("bp_release", {bus.DO_VALID, bus.DI_READY, bus.BUSY}, 3'b010);
    run_vec(vecs[9], "bp_next");

    // Reset 20 cycles into SORT: window discarded, no stale result afterwards.
    send_window(vecs[0]);
    repeat (20) tick();
    pulse_reset();
    check("rsort_do", bus.DO, 0);
    check("rsort_state", {bus.DO_VALID, bus.DI_READY, bus.BUSY}, 3'b010);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.DO_VALID) seen = 1;
    end
    check("rsort_no_stale", seen, 0);
    run_vec(vecs[5], "rsort_next");

    // Reset mid-LOAD coinciding with a DI handshake: partial window and that sample dropped.
    for (int i = 0; i < 4; i++) begin
      bus.DI       = 8'd250;
      bus.DI_VALID = 1'b1;
      bus.MODE     = 2'b01;
      tick();
    end
    bus.DI = 8'd250;
    RST    = 1'b1;
    tick();
    RST          = 1'b0;
    bus.DI_VALID = 1'b0;
    check("rload_busy", bus.BUSY, 0);
    run_vec(vecs[0], "rload_next");

    // Reset in OUT while DO_READY=1 on the same edge: result withdrawn, never re-shown.
    bus.DO_READY = 1'b0;
    send_window(vecs[1]);
    wait_valid(100, n);
    check("rout_lat", n, 9);
    check("rout_do", bus.DO, 9);
    bus.DO_READY = 1'b1;
    pulse_reset();
    check("rout_after", {bus.DO_VALID, bus.DI_READY, bus.BUSY, bus.DO}, {3'b010, 8'd0});
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.DO_VALID) seen = 1;
    end
    check("rout_no_stale", seen, 0);
    run_vec(vecs[2], "rout_next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/median_engine.md
MEDIAN_ENGINE -- requirements
Module: median_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: sample width in bits, minimum 1.
REQ-002 The block SHALL have parameter NUMBER, default 9: samples per window; odd only, range 3..31.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port DI  input  WIDTH  input sample, unsigned.
REQ-006 The block SHALL have port DI_VALID  input  1  DI holds a sample.
REQ-007 The block SHALL have port DI_READY  output  1  block accepts a sample this cycle.
REQ-008 The block SHALL have port MODE  input  2  window operation: 00 median, 01 max, 10 min, 11 median.
REQ-009 The block SHALL have port DO  output  WIDTH  result sample.
REQ-010 The block SHALL have port DO_VALID  output  1  DO holds a result.
REQ-011 The block SHALL have port DO_READY  input  1  consumer accepts DO this cycle.
REQ-012 The block SHALL have port BUSY  output  1  window in progress (SORT or OUT state, or LOAD with at least one sample held).

Function
REQ-013 The block SHALL use a three-state FSM: LOAD, SORT, OUT.
REQ-014 In LOAD, DI_READY SHALL be 1; in SORT and OUT, DI_READY SHALL be 0.
REQ-015 A sample SHALL be accepted on an edge where DI_VALID=1 and DI_READY=1; a DI_VALID gap SHALL not affect accepted samples or the count.
REQ-016 MODE SHALL be captured on the edge accepting the first sample of a window; MODE changes later in that window SHALL be ignored.
REQ-017 On acceptance of the NUMBER-th sample, the FSM SHALL move to SORT and clear the sample counter.
REQ-018 SORT SHALL use one WIDTH-bit unsigned compare-exchange unit, shared, recirculating the sample registers serially; no parallel sorting network.
REQ-019 SORT duration SHALL be P*NUMBER cycles: P=(NUMBER+1)/2 for median, P=1 for max and min.
REQ-020 The result SHALL be the ((NUMBER+1)/2)-th smallest value for median, the largest for max and the smallest for min; equal values count separately.
REQ-021 At the end of SORT, the FSM SHALL move to OUT, load DO and set DO_VALID=1; if the last sample is accepted on edge t, DO_VALID SHALL first be 1 after edge t+P*NUMBER.
REQ-022 In OUT, DO and DO_VALID SHALL stay stable until an edge with DO_READY=1.
REQ-023 On the DO handshake edge, the FSM SHALL return to LOAD; DO_VALID=0 and DI_READY=1 in the next cycle.
REQ-024 DO SHALL keep the last result after DO_VALID falls.
REQ-025 DO_READY SHALL be ignored outside OUT; DI_VALID SHALL be ignored outside LOAD.
REQ-026 DO_VALID SHALL not depend combinationally on DO_READY, and DI_READY SHALL not depend combinationally on DI_VALID.
REQ-027 All comparisons SHALL be unsigned over the full WIDTH; values 0 and 2^WIDTH-1 SHALL need no special handling.

Reset
REQ-028 On an edge with RST=1, the block SHALL enter LOAD, clear the sample counter and clear the captured MODE to median.
REQ-029 In the cycle after a reset edge: DO=0, DO_VALID=0, DI_READY=1, BUSY=0.
REQ-030 RST in any state, including mid-LOAD, mid-SORT and OUT with DO_READY=0, SHALL discard the window; no result of that window SHALL ever appear.
REQ-031 RST SHALL take priority over simultaneous DI or DO handshakes on the same edge, and those handshakes SHALL not complete.
REQ-032 Sample register contents SHALL not need reset; no output SHALL depend on them before a full window is loaded.

Verification (WIDTH=8, NUMBER=9)
REQ-033 Median: MODE=00, DI = 5,1,9,3,7,2,8,6,4 back-to-back, DO_READY=1 -> DO=5, DO_VALID high exactly 45 cycles after the 9th accept, for 1 cycle.
REQ-034 Max/min: same samples with MODE=01 -> DO=9 after 9 cycles; with MODE=10 -> DO=1 after 9 cycles; MODE toggled after the first sample has no effect.
REQ-035 Duplicates/extremes: MODE=00, DI = 7,7,7,0,0,255,255,7,0 with random DI_VALID gaps -> DO=7.
REQ-036 Backpressure: DO_READY=0 for 10 cycles after DO_VALID rises -> DO and DO_VALID stable, DI_READY=0; DO_READY=1 -> DI_READY=1 next cycle; next window produces the correct result.
REQ-037 Reset mid-SORT: RST pulse 20 cycles after the 9th accept -> DO=0, DO_VALID=0, DI_READY=1 next cycle, no stale result; a following window yields its correct median.
